// File: rtl/led_matrix_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_matrix_scanner: fetches playfield rows and scans them out serially   |
// | to the LED column drivers, latching and lighting one row at a time.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module led_matrix_scanner #(
  parameter int WIDTH  = 32,
  parameter int NROWS  = 32,
  parameter int CLKDIV = 2,
  parameter int BLANK  = 2,
  parameter int HOLD   = 64,
  localparam int AW    = $clog2(NROWS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] RowData,
  output logic [AW-1:0]    RowAddr,
  output logic             SDO,
  output logic             SCLK,
  output logic             LATCH,
  output logic             OE_N,
  output logic [AW-1:0]    ROW_SEL,
  output logic             FrameDone,
  output logic             Busy
);

  localparam int DIVW   = $clog2(2 * CLKDIV);
  localparam int BITW   = $clog2(WIDTH);
  localparam int CNTMAX = (BLANK > HOLD) ? BLANK : HOLD;
  localparam int CW     = $clog2(CNTMAX + 1);

  localparam logic [DIVW-1:0] DIV_LAST   = DIVW'(2 * CLKDIV - 1);
  localparam logic [DIVW-1:0] DIV_RISE   = DIVW'(CLKDIV - 1);
  localparam logic [BITW-1:0] BIT_LAST   = BITW'(WIDTH - 1);
  localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0]   BLANK_PRE  = CW'(BLANK - 2);
  localparam logic [CW-1:0]   HOLD_LAST  = CW'(HOLD - 1);
  localparam logic [CW-1:0]   HOLD_PRE   = CW'(HOLD - 2);
  localparam logic [AW-1:0]   ROW_LAST   = AW'(NROWS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_BLANK = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t           state;
  logic [AW-1:0]    row_cnt;
  logic [CW-1:0]    cnt;
  logic [DIVW-1:0]  div_cnt;
  logic [BITW-1:0]  bit_cnt;
  // The MSB goes straight to SDO at capture; only the remaining bits are held.
  logic [WIDTH-2:0] shreg;

  assign RowAddr = row_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      row_cnt   <= '0;
      cnt       <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      SDO       <= 1'b0;
      SCLK      <= 1'b0;
      LATCH     <= 1'b0;
      OE_N      <= 1'b1;
      ROW_SEL   <= '0;
      FrameDone <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      LATCH     <= 1'b0;
      FrameDone <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (EN) begin
            state <= ST_FETCH;
            Busy  <= 1'b1;
          end
        end
        ST_FETCH: begin
          shreg   <= RowData[WIDTH-2:0];
          SDO     <= RowData[WIDTH-1];
          SCLK    <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
          state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            SCLK    <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              SDO   <= 1'b0;
              OE_N  <= 1'b1;
              cnt   <= '0;
              state <= ST_BLANK;
              if (BLANK == 1) begin
                LATCH   <= 1'b1;
                ROW_SEL <= row_cnt;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              SDO     <= shreg[WIDTH-2];
              shreg   <= {shreg[WIDTH-3:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
            // SCLK rises once the low half of the bit period has elapsed.
            SCLK    <= (div_cnt >= DIV_RISE);
          end
        end
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt   <= '0;
            OE_N  <= 1'b0;
            state <= ST_HOLD;
            if (HOLD == 1) FrameDone <= (row_cnt == ROW_LAST);
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == BLANK_PRE) begin
              LATCH   <= 1'b1;
              ROW_SEL <= row_cnt;
            end
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt     <= '0;
            row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
            if (EN) begin
              state <= ST_FETCH;
            end else begin
              state <= ST_IDLE;
              OE_N  <= 1'b1;
              Busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == HOLD_PRE && row_cnt == ROW_LAST) FrameDone <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          SDO   <= 1'b0;
          SCLK  <= 1'b0;
          OE_N  <= 1'b1;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_led_matrix_scanner: scoreboard bench for led_matrix_scanner.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_led_matrix_scanner;

  localparam int WIDTH    = 32;
  localparam int NROWS    = 32;
  localparam int CLKDIV   = 2;
  localparam int BLANK    = 2;
  localparam int HOLD     = 64;
  localparam int SHIFTLEN = WIDTH * 2 * CLKDIV;
  localparam int ROW_LEN  = 1 + SHIFTLEN + BLANK + HOLD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] row_data;
  logic [4:0]  row_addr;
  logic        sdo, sclk, latch, oe_n, frame_done, busy;
  logic [4:0]  row_sel;

  logic [31:0] mem [NROWS];
  assign row_data = mem[row_addr];

  always #5 clk = ~clk;

  led_matrix_scanner dut (
    .CLK(clk), .RST(rst_n), .EN(en), .RowData(row_data), .RowAddr(row_addr),
    .SDO(sdo), .SCLK(sclk), .LATCH(latch), .OE_N(oe_n), .ROW_SEL(row_sel),
    .FrameDone(frame_done), .Busy(busy)
  );

  int errors = 0;
  int checks = 0;

  // Interval n is the time between rising edge n and rising edge n+1.
  function automatic int now_cyc();
    return int'(($time + 5) / 10);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, now_cyc());
    end
  endtask

  typedef struct {
    int          row;
    logic [31:0] data;
    int          latch_at;
  } exp_t;

  exp_t exp_q[$];
  int   frame_q[$];
  bit   run_on = 1'b0;
  bit   mutate = 1'b0;
  int   latch_count = 0;

  // Reference model: one row per ROW_LEN cycles, data snapshotted at the
  // end of the fetch cycle, EN looked at only when idle or at row end.
  initial begin : model
    int   f;
    int   row;
    bit   go;
    exp_t rec;
    row = 0;
    wait (run_on);
    forever begin
      do @(posedge clk); while (en !== 1'b1);
      f  = now_cyc();
      go = 1'b1;
      while (go) begin
        @(posedge clk);
        rec.row      = row;
        rec.data     = mem[row];
        rec.latch_at = f + SHIFTLEN + BLANK;
        exp_q.push_back(rec);
        if (row == NROWS - 1) frame_q.push_back(f + ROW_LEN - 1);
        repeat (ROW_LEN - 1) @(posedge clk);
        row = (row + 1) % NROWS;
        if (en === 1'b1) f = f + ROW_LEN;
        else go = 1'b0;
      end
    end
  end

  // Monitor: rebuilds each shifted word from SDO at SCLK rises and checks
  // it against the scoreboard whenever the DUT pulses LATCH or FrameDone.
  initial begin : monitor
    logic [31:0] word;
    int   rises, hi_len, bad_hi, oe_run, last_latch;
    bit   sclk_q, oe_pending;
    exp_t e;
    word = '0; rises = 0; hi_len = 0; bad_hi = 0; oe_run = 0;
    last_latch = -100000; sclk_q = 1'b0; oe_pending = 1'b0;
    wait (run_on);
    forever begin
      @(negedge clk);
      if (sclk && !sclk_q) begin
        word = {word[30:0], sdo};
        rises++;
      end
      if (sclk) hi_len++;
      else begin
        if (sclk_q && hi_len != CLKDIV) bad_hi++;
        hi_len = 0;
      end
      if (oe_n) oe_run++;
      else oe_run = 0;
      if (oe_pending) begin
        check("oe_n_after_latch", oe_n, 0);
        oe_pending = 1'b0;
      end
      if (latch) begin
        latch_count++;
        if (exp_q.size() == 0) check("latch_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("shift_word", word, e.data);
          check("sclk_rises", rises, WIDTH);
          check("sclk_high_len_bad", bad_hi, 0);
          check("latch_cycle", now_cyc(), e.latch_at);
          check("row_sel", row_sel, e.row);
          if (last_latch == now_cyc() - ROW_LEN) check("oe_n_blank_len", oe_run, BLANK);
        end
        last_latch = now_cyc();
        oe_pending = 1'b1;
        word = '0; rises = 0; bad_hi = 0;
      end
      if (frame_done) begin
        if (frame_q.size() == 0) check("frame_done_unexpected", 1, 0);
        else check("frame_done_cycle", now_cyc(), frame_q.pop_front());
      end
      sclk_q = sclk;
    end
  end

  task automatic run_until(input int c);
    while (now_cyc() < c) begin
      @(negedge clk);
      if (mutate && $urandom_range(7) == 0) mem[$urandom_range(NROWS - 1)] = $urandom;
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : stimulus
    int f0, fd, f1;
    for (int i = 0; i < NROWS; i++) mem[i] = $urandom;

    // Reset values, then an asynchronous reset in the middle of SHIFT.
    repeat (3) @(negedge clk);
    check("reset_outputs", {row_addr, row_sel, sdo, sclk, latch, oe_n, frame_done, busy}, 16'h0004);
    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);
    repeat (23) @(negedge clk);
    check("sclk_before_async_reset", sclk, 1);
    check("busy_before_async_reset", busy, 1);
    #3 rst_n = 1'b0;
    #1 check("async_reset_outputs", {row_addr, row_sel, sdo, sclk, latch, oe_n, frame_done, busy}, 16'h0004);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_on = 1'b1;

    // First frame: row 0 edge pattern, row 3 snapshot, others hold their index.
    for (int i = 0; i < NROWS; i++) mem[i] = 32'(i);
    mem[0] = 32'h8000_0001;
    mem[3] = 32'hFFFF_FFFF;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    f0 = now_cyc();
    check("first_fetch_row_addr", row_addr, 0);
    check("first_fetch_busy", busy, 1);
    run_until(f0 + 3 * ROW_LEN + 1);
    mem[3] = 32'h0000_0000;
    run_until(f0 + NROWS * ROW_LEN);
    check("frame_wrap_row_addr", row_addr, 0);

    // Second frame with random contents changing underneath the scan.
    for (int i = 0; i < NROWS; i++) mem[i] = $urandom;
    mutate = 1'b1;
    fd = f0 + 42 * ROW_LEN;
    run_until(fd + 1 + 10 * 2 * CLKDIV);
    en = 1'b0;
    run_until(fd + ROW_LEN - 1);
    check("en_drop_hold_busy", busy, 1);
    check("en_drop_hold_oe_n", oe_n, 0);
    run_until(fd + ROW_LEN + 1);
    check("en_drop_idle_busy", busy, 0);
    check("en_drop_idle_oe_n", oe_n, 1);
    run_until(fd + ROW_LEN + 10);
    en = 1'b1;
    @(negedge clk);
    f1 = now_cyc();
    check("resume_row_addr", row_addr, 11);
    check("resume_busy", busy, 1);
    run_until(f1 + 2 * ROW_LEN + 100);
    en = 1'b0;
    run_until(f1 + 3 * ROW_LEN + 5);
    check("final_idle_busy", busy, 0);
    mutate = 1'b0;
    repeat (5) @(negedge clk);
    check("pending_rows", exp_q.size(), 0);
    check("pending_frames", frame_q.size(), 0);
    check("latch_total", latch_count, 46);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
- Reads the 32 row registers of the Tetris playfield one row at a time and scans them out to the physical LED matrix.
- Each row is serialised over a shift interface (SDO/SCLK), latched into the column drivers, and its row line is selected.
- Sits downstream of the row-register array. It is the reader side of the row bus those registers write.
- The row-register array and its read mux stay outside this block; the scanner only drives RowAddr and samples RowData.

Parameters:
- WIDTH, 32, columns per row = bits shifted per row.
- NROWS, 32, rows per frame; RowAddr/ROW_SEL width AW = clog2(NROWS) = 5.
- CLKDIV, 2, CLK cycles per SCLK half-period (>=1).
- BLANK, 2, OE_N-high cycles before latch (>=1).
- HOLD, 64, display cycles per row after latch (>=1).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- EN  in  1  scan enable.
- RowData  in  WIDTH  row contents for RowAddr, combinational read path (0-cycle).
- RowAddr  out  AW  row being fetched.
- SDO  out  1  serial column data, MSB (column WIDTH-1) first.
- SCLK  out  1  shift clock; driver samples SDO on SCLK rising edge.
- LATCH  out  1  1-cycle high pulse transfers shifted word to column outputs.
- OE_N  out  1  column output enable, active-low.
- ROW_SEL  out  AW  row line currently lit.
- FrameDone  out  1  1-cycle pulse after last row of a frame.
- Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (RST=0, immediate, regardless of state):
  - State IDLE, row counter 0.
  - RowAddr=0, ROW_SEL=0, SDO=0, SCLK=0, LATCH=0, OE_N=1, FrameDone=0, Busy=0.
- States: IDLE -> FETCH -> SHIFT -> BLANK -> HOLD -> (FETCH | IDLE).
- IDLE:
  - OE_N=1, SCLK=0, SDO=0.
  - EN=1 moves to FETCH with the row counter unchanged.
- FETCH (1 cycle):
  - RowAddr = row counter; RowData is captured into the shift register at the end of this cycle.
  - RowData changes after this cycle do not affect the row in flight.
- SHIFT (WIDTH*2*CLKDIV cycles):
  - Bit k = WIDTH-1..0: SDO holds the bit for 2*CLKDIV cycles, with SCLK low for the first CLKDIV cycles and high for the last CLKDIV.
  - SCLK returns to 0 on exit.
  - OE_N keeps its prior value: the previously latched row stays lit during SHIFT.
- BLANK (BLANK cycles):
  - OE_N=1.
  - LATCH=1 in the last BLANK cycle only.
  - ROW_SEL is loaded with the row counter in that same cycle.
- HOLD (HOLD cycles):
  - OE_N=0, SDO=0.
  - In the last HOLD cycle the row counter increments, wrapping NROWS-1 -> 0; FrameDone=1 in that cycle only when the wrap occurs.
  - Next state is FETCH if EN=1, otherwise IDLE.
- EN is sampled only in IDLE and in the last HOLD cycle. A row in progress always completes.
- Row period = 1 + WIDTH*2*CLKDIV + BLANK + HOLD; defaults give 195 cycles. Frame = NROWS * 195 = 6240 cycles.
- Counters are sized to hold their maximum values without overflow. No wrap occurs other than the row counter.

Test Plan:
- Async reset: pull RST low mid-SHIFT without a CLK edge -> all outputs at reset values within the same time step; after release with EN=1, FETCH starts with RowAddr=0.
- Pattern: RowData=0x80000001 for row 0, EN=1 -> SDO sequence over 32 SCLK rises is 1, 0 (x30), 1; exactly 32 SCLK rising edges; each SCLK high phase lasts 2 cycles.
- Timing: with defaults, measure from the FETCH cycle to the next FETCH -> 195 cycles; LATCH is high exactly 1 cycle, at cycle offset 130; OE_N is high for cycles 129-130 only.
- Snapshot: change RowData from 0xFFFFFFFF to 0x00000000 one cycle after FETCH -> SDO shifts all ones.
- Frame wrap: run 32 rows with RowData = {27'b0, RowAddr} -> ROW_SEL steps 0..31 then returns to 0; one FrameDone pulse at cycle 6239 after the first FETCH; the next RowAddr is 0.
- EN drop: deassert EN at SHIFT bit 10 -> the row completes (latch, full HOLD); the block then enters IDLE with OE_N=1 and Busy=0; reasserting EN resumes at the next row index.
